// File: rtl/matrix_fifo_reader.sv
// Read-side consumer for the matrix buffer FIFO: issues credit-limited reads, compensates
// the FIFO read latency and streams one frame with sof/eol/eof markers over valid/ready.
module matrix_fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int RD_LATENCY = 1
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  frame_start,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof
);
  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int REQ_W = $clog2(TOTAL + 1);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int DEPTH = RD_LATENCY + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CLM_W = CNT_W + 1;

  localparam logic [REQ_W-1:0] LAST_REQ = REQ_W'(TOTAL - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CLM_W-1:0] CREDIT   = CLM_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  typedef struct packed { logic sof; logic eol; logic eof; } tag_t;
  typedef struct packed { logic [DATA_WIDTH-1:0] data; tag_t tag; } entry_t;

  state_t                state, state_next;
  logic                  done_next;
  logic [REQ_W-1:0]      req_cnt;
  logic [COL_W-1:0]      col_cnt;
  logic [ROW_W-1:0]      row_cnt;
  logic [RD_LATENCY-1:0] pipe_vld;
  tag_t                  pipe_tag [RD_LATENCY];
  entry_t                mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      buf_count, inflight;
  logic [CLM_W-1:0]      claims, claims_after;
  logic                  buf_empty, push, pop, do_write, do_read;
  entry_t                in_entry, head;
  tag_t                  issue_tag;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state      <= IDLE;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= done_next;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE:    if (frame_start) state_next = RUN;
      RUN:     if (fifo_rd_en && req_cnt == LAST_REQ) state_next = FLUSH;
      FLUSH:   if (claims_after == '0) begin
                 state_next = IDLE;
                 done_next  = 1'b1;
               end
      default: state_next = IDLE;
    endcase
  end

  // Reads are tagged with their raster position at issue time.
  always_comb begin
    issue_tag.sof = (col_cnt == '0) && (row_cnt == '0);
    issue_tag.eol = (col_cnt == COL_LAST);
    issue_tag.eof = (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      req_cnt <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (state == IDLE && frame_start) begin
      req_cnt <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (fifo_rd_en) begin
      req_cnt <= req_cnt + REQ_W'(1);
      if (col_cnt == COL_LAST) begin
        col_cnt <= '0;
        row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + ROW_W'(1);
      end else begin
        col_cnt <= col_cnt + COL_W'(1);
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= fifo_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  always_ff @(posedge rd_clk) begin
    pipe_tag[0] <= issue_tag;
    for (int i = 1; i < RD_LATENCY; i++) pipe_tag[i] <= pipe_tag[i-1];
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CNT_W'(pipe_vld[i]);
  end

  // Credit counts buffered plus in-flight words; a pop in the same cycle frees one slot.
  always_comb begin
    push         = pipe_vld[RD_LATENCY-1];
    in_entry     = '{data: fifo_rd_data, tag: pipe_tag[RD_LATENCY-1]};
    buf_empty    = (buf_count == '0);
    head         = buf_empty ? in_entry : mem[rd_ptr];
    m_valid      = !buf_empty || push;
    pop          = m_valid && m_ready;
    do_write     = push && !(buf_empty && pop);
    do_read      = pop && !buf_empty;
    claims       = CLM_W'(buf_count) + CLM_W'(inflight);
    claims_after = claims - CLM_W'(pop);
    fifo_rd_en   = (state == RUN) && !fifo_rd_empty && (req_cnt < REQ_W'(TOTAL))
                   && (claims_after < CREDIT);
    busy         = (state != IDLE);
    m_data       = m_valid ? head.data : '0;
    m_sof        = m_valid && head.tag.sof;
    m_eol        = m_valid && head.tag.eol;
    m_eof        = m_valid && head.tag.eof;
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_count <= '0;
    end else begin
      if (do_write) wr_ptr <= ptr_inc(wr_ptr);
      if (do_read)  rd_ptr <= ptr_inc(rd_ptr);
      buf_count <= buf_count + CNT_W'(do_write) - CNT_W'(do_read);
    end
  end

  // NOTE: storage is not reset; occupancy is tracked by buf_count and outputs are gated by m_valid.
  always_ff @(posedge rd_clk) begin
    if (do_write) mem[wr_ptr] <= in_entry;
  end

endmodule
